alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Multi-cycle sequencer that drives the 8-bit ALU datapath. It fetches 9-bit instructions from instruction memory and decodes them into ALU opcode, register-file addresses and constant. It then captures the ALU result, overflow and branch outcome, and commits each instruction with a register-file write and a PC update. The block sits between the instruction ROM, the 4-entry register file and the ALU, and owns the program counter.

## Interface
- PC_W, 8, program counter width; instruction address space is 2^PC_W
- START_ADDR, 0, PC value loaded on reset and on each accepted start
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin execution at START_ADDR; honoured only in IDLE
- instr  in  9  instruction word at address pc (combinational ROM read)
- alu_out  in  8  ALU result
- alu_overflow  in  1  ALU carry-out; meaningful for add only
- alu_taken  in  1  ALU branch flag; meaningful for eq0 and jmp only
- pc  out  PC_W  program counter / ROM address
- alu_opcode  out  4  opcode to ALU
- alu_const  out  2  2-bit immediate to ALU
- rf_raddr1  out  2  register-file read port 1 (ra)
- rf_raddr2  out  2  register-file read port 2 (rb)
- rf_waddr  out  2  write address (ra)
- rf_wdata  out  8  write data (latched result)
- rf_we  out  1  write enable, one cycle per writing instruction
- ov_flag  out  1  sticky overflow, set by any add that overflows
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on halt
- cycle_count  out  16  clocks spent busy, saturating

## Operation
- Instruction fields: opcode = instr[8:5], ra = instr[4:3], rb = instr[2:1], imm = instr[2:1] (the same bits as rb), boff = instr[2:0] sign-extended to PC_W.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: on start, pc <= START_ADDR, ov_flag <= 0, cycle_count <= 0, then go to FETCH.
- FETCH: IR <= instr. Go to DECODE.
- DECODE:
  - alu_opcode = IR opcode, alu_const = imm, rf_raddr1 = ra, rf_raddr2 = rb. These outputs are held through EXEC and WB.
  - Go to EXEC.
- EXEC, opcode 4'b1111 (halt): go to HALT.
- EXEC, any other opcode:
  - result <= alu_out.
  - taken_q <= alu_taken only for 0101 and 1011; otherwise taken_q <= 0. alu_taken is ignored for every other opcode because it is undriven there.
  - If opcode is 0000 and alu_overflow = 1, ov_flag <= 1.
  - Go to WB.
- WB:
  - rf_we = 1 for opcodes 0000–0100, 0110–1010 and 1100. rf_we = 0 for 0101, 1011, 1101 and 1110 (1101 and 1110 are NOPs).
  - pc update: 1011 with taken_q gives pc <= result[PC_W-1:0]; 0101 with taken_q gives pc <= pc + boff; otherwise pc <= pc + 1.
  - Go to FETCH.
- HALT: done = 1 for this cycle; pc is not incremented. Go to IDLE.
- PC arithmetic is modulo 2^PC_W; 0xFF + 1 wraps to 0x00 (PC_W = 8).
- cycle_count increments on every clock while busy and saturates at 0xFFFF.

## Timing
- Every non-halt instruction takes 4 cycles (FETCH, DECODE, EXEC, WB). Halt takes 4 cycles (FETCH, DECODE, EXEC, HALT).
- From start sampled high in IDLE to the first rf_we: 4 cycles.
- instr is sampled only at the end of FETCH. ALU outputs are sampled only at the end of EXEC.
- rf_we, rf_waddr and rf_wdata are valid together in the WB cycle. The register file writes on the clk edge that ends WB.
- Reset values: pc = START_ADDR, state IDLE, alu_opcode = 0, alu_const = 0, all rf_* = 0, rf_we = 0, ov_flag = 0, busy = 0, done = 0, cycle_count = 0.
- Reset mid-instruction: at the next edge the block is in IDLE with reset values. rf_we never asserts in the cycle following reset.
- start while busy is ignored. start in the same cycle as done is ignored; it is honoured once the block is back in IDLE.
- rst_n low takes priority over start.

## Test plan
- Reset then start; ROM[0] = add r1,r2 (opcode 0000) with ALU returning 0x34 and overflow 0 -> in cycle 4 after start: rf_we = 1, rf_waddr = 1, rf_wdata = 0x34; then pc = 1, ov_flag = 0.
- add with alu_overflow = 1, followed by three non-add ops -> ov_flag = 1 and stays 1; cleared only by reset or the next accepted start.
- eq0 at pc = 0x10 with alu_taken = 1 and boff = 3'b110 (-2) -> pc = 0x0E, rf_we stays 0. Same instruction with alu_taken = 0 -> pc = 0x11.
- jmp with alu_out = 0x40 -> pc = 0x40, no write. An xor with stray alu_taken = 1 -> pc + 1.
- PC at 0xFF executing a NOP -> pc wraps to 0x00. Halt at 0x05 -> done pulses once, busy drops the next cycle, pc = 0x05, cycle_count = 4 × (instructions executed).
- Drop rst_n during EXEC of an add -> no rf_we pulse, outputs at reset values. A second start pulse while busy -> no effect on pc.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle fetch/decode/exec/writeback sequencer for the
// 8-bit ALU datapath. Owns the PC, the instruction register, the latched ALU
// result and the sticky overflow flag.
module alu_seq_ctrl #(
    parameter int              PC_W       = 8,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [8:0]      instr,
    input  logic [7:0]      alu_out,
    input  logic            alu_overflow,
    input  logic            alu_taken,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      alu_opcode,
    output logic [1:0]      alu_const,
    output logic [1:0]      rf_raddr1,
    output logic [1:0]      rf_raddr2,
    output logic [1:0]      rf_waddr,
    output logic [7:0]      rf_wdata,
    output logic            rf_we,
    output logic            ov_flag,
    output logic            busy,
    output logic            done,
    output logic [15:0]     cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_EQ0  = 4'b0101;
    localparam logic [3:0] OP_JMP  = 4'b1011;
    localparam logic [3:0] OP_NOP1 = 4'b1101;
    localparam logic [3:0] OP_NOP2 = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t          state, state_nxt;
    logic [8:0]      ir;
    logic [7:0]      result;
    logic            taken_q;
    logic [3:0]      op;
    logic [PC_W-1:0] boff;
    logic [PC_W-1:0] pc_nxt;
    logic            writes;

    // Decode straight off the IR; it only changes at the end of FETCH, so the
    // ALU controls stay stable across DECODE, EXEC and WB.
    assign op         = ir[8:5];
    assign alu_opcode = op;
    assign alu_const  = ir[2:1];
    assign rf_raddr1  = ir[4:3];
    assign rf_raddr2  = ir[2:1];
    assign rf_waddr   = ir[4:3];
    assign rf_wdata   = result;
    assign boff       = {{(PC_W-3){ir[2]}}, ir[2:0]};

    assign writes  = !(op == OP_EQ0 || op == OP_JMP || op == OP_NOP1 ||
                       op == OP_NOP2 || op == OP_HALT);
    assign rf_we   = (state == S_WB) && writes;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_HALT);

    // Branch target selection; wraps modulo 2^PC_W.
    always_comb begin
        pc_nxt = pc + 1'b1;
        if (op == OP_JMP && taken_q)
            pc_nxt = PC_W'(result);
        else if (op == OP_EQ0 && taken_q)
            pc_nxt = pc + boff;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state sequencing; start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = (op == OP_HALT) ? S_HALT : S_WB;
            S_WB:     state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers: PC, IR, result/branch capture, flags, busy counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= START_ADDR;
            ir          <= '0;
            result      <= '0;
            taken_q     <= 1'b0;
            ov_flag     <= 1'b0;
            cycle_count <= '0;
        end else begin
            if (busy && cycle_count != 16'hFFFF)
                cycle_count <= cycle_count + 16'd1;
            case (state)
                S_IDLE: if (start) begin
                    pc          <= START_ADDR;
                    ov_flag     <= 1'b0;
                    cycle_count <= '0;
                end
                S_FETCH: ir <= instr;
                S_EXEC: if (op != OP_HALT) begin
                    result  <= alu_out;
                    // alu_taken is undriven outside the branch opcodes
                    taken_q <= (op == OP_EQ0 || op == OP_JMP) && alu_taken;
                    if (op == OP_ADD && alu_overflow) ov_flag <= 1'b1;
                end
                S_WB: pc <= pc_nxt;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: ROM model indexed by pc, ALU outputs
// driven directly, expected values hand-computed per step.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  instr;
    logic [7:0]  alu_out = 8'h00;
    logic        alu_overflow = 1'b0;
    logic        alu_taken = 1'b0;
    logic [7:0]  pc;
    logic [3:0]  alu_opcode;
    logic [1:0]  alu_const, rf_raddr1, rf_raddr2, rf_waddr;
    logic [7:0]  rf_wdata;
    logic        rf_we, ov_flag, busy, done;
    logic [15:0] cycle_count;

    logic [8:0]  rom [256];
    int          n_vec = 0;
    int          n_err = 0;

    localparam logic [8:0] NOP  = 9'h1A0;  // 1101_00_00_0
    localparam logic [8:0] HALT = 9'h1E0;  // 1111_00_00_0
    localparam logic [8:0] JMP  = 9'h160;  // 1011_00_00_0

    assign instr = rom[pc];

    always #5 clk = ~clk;

    alu_seq_ctrl #(.PC_W(8), .START_ADDR(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
        .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_taken(alu_taken),
        .pc(pc), .alu_opcode(alu_opcode), .alu_const(alu_const),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .rf_we(rf_we), .ov_flag(ov_flag), .busy(busy),
        .done(done), .cycle_count(cycle_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = NOP;
    endtask

    function automatic logic [8:0] enc(input logic [3:0] op, input logic [1:0] ra,
                                       input logic [1:0] rb, input logic b0);
        return {op, ra, rb, b0};
    endfunction

    // Leaves the bench #1 after the start edge, i.e. in the FETCH cycle (cycle 1).
    task automatic start_run();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        clear_rom();
        do_reset();

        // reset state
        chk("rst_pc", pc, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_we", rf_we, 1'b0);
        chk("rst_ov", ov_flag, 1'b0);
        chk("rst_cc", cycle_count, 16'd0);
        chk("rst_opc", alu_opcode, 4'h0);

        // add r1,r2 then halt
        rom[0] = enc(4'b0000, 2'd1, 2'd2, 1'b0);
        rom[1] = HALT;
        alu_out = 8'h34;
        start_run();
        tick(3);
        chk("add_we", rf_we, 1'b1);
        chk("add_waddr", rf_waddr, 2'd1);
        chk("add_wdata", rf_wdata, 8'h34);
        chk("add_raddr2", rf_raddr2, 2'd2);
        tick(1);
        chk("add_pc", pc, 8'h01);
        chk("add_ov", ov_flag, 1'b0);
        tick(3);
        chk("halt1_done", done, 1'b1);
        chk("halt1_pc", pc, 8'h01);
        tick(1);
        chk("halt1_busy", busy, 1'b0);
        chk("halt1_donelow", done, 1'b0);
        chk("halt1_cc", cycle_count, 16'd8);

        // overflow from a non-add must not set the flag
        rom[0] = enc(4'b0001, 2'd0, 2'd0, 1'b0);
        alu_overflow = 1'b1;
        start_run();
        tick(8);
        chk("sub_ov", ov_flag, 1'b0);

        // add overflow is sticky through three non-adds
        rom[0] = enc(4'b0000, 2'd0, 2'd1, 1'b0);
        rom[1] = enc(4'b0001, 2'd1, 2'd0, 1'b0);
        rom[2] = enc(4'b0010, 2'd2, 2'd0, 1'b0);
        rom[3] = NOP;
        rom[4] = HALT;
        start_run();
        tick(4);
        chk("ov_set", ov_flag, 1'b1);
        tick(12);
        chk("ov_sticky", ov_flag, 1'b1);
        tick(4);
        chk("ov_idle", ov_flag, 1'b1);
        chk("ov_cc", cycle_count, 16'd20);
        alu_overflow = 1'b0;
        rom[0] = HALT;
        start_run();
        chk("ov_clr_start", ov_flag, 1'b0);
        chk("cc_clr_start", cycle_count, 16'd0);
        tick(4);

        // jmp to 0x10, eq0 taken with boff=-2 -> 0x0E (halt there)
        clear_rom();
        rom[8'h00] = JMP;
        rom[8'h10] = enc(4'b0101, 2'd3, 2'd3, 1'b0);  // boff = 3'b110
        rom[8'h0E] = HALT;
        rom[8'h11] = HALT;
        alu_out = 8'h10;
        alu_taken = 1'b1;
        start_run();
        tick(3);
        chk("jmp_we", rf_we, 1'b0);
        tick(1);
        chk("jmp_pc", pc, 8'h10);
        tick(3);
        chk("eq0_we", rf_we, 1'b0);
        tick(1);
        chk("eq0_taken_pc", pc, 8'h0E);
        tick(3);
        chk("eq0_halt_done", done, 1'b1);
        tick(1);
        chk("eq0_cc", cycle_count, 16'd12);

        // eq0 not taken -> pc + 1
        start_run();
        tick(4);
        alu_taken = 1'b0;
        tick(4);
        chk("eq0_nt_pc", pc, 8'h11);
        tick(4);

        // jmp to 0x40, then a writing op with stray alu_taken
        clear_rom();
        rom[8'h00] = JMP;
        rom[8'h40] = enc(4'b0100, 2'd2, 2'd0, 1'b0);
        rom[8'h41] = HALT;
        alu_out = 8'h40;
        alu_taken = 1'b1;
        start_run();
        tick(4);
        chk("jmp40_pc", pc, 8'h40);
        tick(3);
        chk("xor_we", rf_we, 1'b1);
        chk("xor_waddr", rf_waddr, 2'd2);
        chk("xor_wdata", rf_wdata, 8'h40);
        tick(1);
        chk("xor_pc", pc, 8'h41);
        tick(4);

        // pc wrap: jmp 0xFF, NOP at 0xFF -> 0x00
        clear_rom();
        rom[8'h00] = JMP;
        alu_out = 8'hFF;
        start_run();
        tick(4);
        chk("wrap_pre", pc, 8'hFF);
        tick(3);
        chk("wrap_nop_we", rf_we, 1'b0);
        tick(1);
        chk("wrap_pc", pc, 8'h00);
        do_reset();
        alu_taken = 1'b0;

        // halt at 0x05, with a stray start while busy and one during done
        clear_rom();
        rom[8'h05] = HALT;
        start_run();
        tick(9);
        chk("busy_pc_before", pc, 8'h02);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("busy_start_pc", pc, 8'h02);
        tick(12);
        chk("h5_pre_done", done, 1'b0);
        tick(1);
        chk("h5_done", done, 1'b1);
        chk("h5_pc", pc, 8'h05);
        start = 1'b1;
        tick(1);
        chk("h5_start_ignored", busy, 1'b0);
        chk("h5_done_once", done, 1'b0);
        chk("h5_pc_held", pc, 8'h05);
        chk("h5_cc", cycle_count, 16'd24);
        tick(1);
        start = 1'b0;
        chk("h5_restart", busy, 1'b1);
        chk("h5_restart_pc", pc, 8'h00);
        do_reset();

        // reset during EXEC of an add
        rom[0] = enc(4'b0000, 2'd1, 2'd2, 1'b0);
        alu_out = 8'h77;
        start_run();
        tick(2);
        chk("mid_raddr1", rf_raddr1, 2'd1);
        rst_n = 1'b0;
        tick(1);
        chk("mid_we", rf_we, 1'b0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_raddr1_rst", rf_raddr1, 2'd0);
        chk("mid_wdata", rf_wdata, 8'h00);
        chk("mid_cc", cycle_count, 16'd0);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_we", rf_we, 1'b0);
        chk("post_rst_pc", pc, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
